// File: rtl/axi_lite_cmd_master.sv
// Command-to-AXI-Lite bridge: takes one read/write command, runs the AXI-Lite transaction on the
// m_axi_* port and returns data/status. One transaction in flight; optional per-phase timeout.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_RSP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_busy;
  logic             w_abort;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_wr_done;

  assign cmd_ready = (r_state == S_IDLE);
  assign w_busy    = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                     (r_state == S_RD_REQ) || (r_state == S_RD_DATA);
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  // Abort on the edge where the wait count would reach TIMEOUT; TIMEOUT=0 never aborts.
  assign w_abort   = (TIMEOUT != 0) && w_busy && (w_cnt_inc == CNT_W'(TIMEOUT));
  assign w_aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_w_hs    = m_axi_wvalid && m_axi_wready;
  // Each channel is done once it has handshaken, either earlier (valid already low) or now.
  assign w_wr_done = (!m_axi_awvalid || w_aw_hs) && (!m_axi_wvalid || w_w_hs);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_timeout   <= 1'b0;
    end else if (w_abort) begin
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b1;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b10;
      rsp_timeout   <= 1'b1;
      r_state       <= S_RSP;
    end else begin
      r_cnt <= w_cnt_inc;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (cmd_valid) begin
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= cmd_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              r_state       <= S_WR_REQ;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              r_state       <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (w_aw_hs) m_axi_awvalid <= 1'b0;
          if (w_w_hs)  m_axi_wvalid  <= 1'b0;
          if (w_wr_done) begin
            m_axi_bready <= 1'b1;
            r_cnt        <= '0;
            r_state      <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_timeout  <= 1'b0;
            r_state      <= S_RSP;
          end
        end
        S_RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_timeout  <= 1'b0;
            r_state      <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a small AXI-Lite register slave model
// (4 x 32-bit words, configurable ready delays).
module tb_axi_lite_cmd_master;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp;

  int checks = 0;
  int errors = 0;

  axi_lite_cmd_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  // Slave model
  int          aw_delay = 1, w_delay = 1, ar_delay = 1;
  bit          ar_never = 1'b0, b_block = 1'b0;
  logic [31:0] mem [4];
  int          aw_cnt, w_cnt, ar_cnt, n_aw = 0, n_w = 0, n_b = 0;
  logic        aw_done_s, w_done_s;
  logic        s_aw_hs, s_w_hs, s_ar_hs, s_awd, s_wd;

  assign s_aw_hs = m_axi_awvalid && m_axi_awready;
  assign s_w_hs  = m_axi_wvalid && m_axi_wready;
  assign s_ar_hs = m_axi_arvalid && m_axi_arready;
  assign s_awd   = aw_done_s || s_aw_hs;
  assign s_wd    = w_done_s || s_w_hs;

  initial for (int i = 0; i < 4; i++) mem[i] = 32'h0;

  always @(posedge aclk) begin
    if (areset) begin
      m_axi_awready <= 1'b0; m_axi_wready <= 1'b0; m_axi_bvalid <= 1'b0;
      m_axi_arready <= 1'b0; m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= 2'b00;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; aw_done_s <= 1'b0; w_done_s <= 1'b0;
    end else begin
      if (s_aw_hs) begin
        m_axi_awready <= 1'b0; aw_cnt <= 0; n_aw <= n_aw + 1;
      end else if (m_axi_awvalid && !m_axi_awready) begin
        if (aw_cnt + 1 >= aw_delay) m_axi_awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
      end
      if (s_w_hs) begin
        m_axi_wready <= 1'b0; w_cnt <= 0; n_w <= n_w + 1;
      end else if (m_axi_wvalid && !m_axi_wready) begin
        if (w_cnt + 1 >= w_delay) m_axi_wready <= 1'b1; else w_cnt <= w_cnt + 1;
      end
      // The write lands using the bus address/data at the moment both channels are done.
      if (s_awd && s_wd) begin
        for (int b = 0; b < 4; b++)
          if (m_axi_wstrb[b]) mem[m_axi_awaddr[3:2]][8*b +: 8] <= m_axi_wdata[8*b +: 8];
        if (!b_block) m_axi_bvalid <= 1'b1;
        aw_done_s <= 1'b0; w_done_s <= 1'b0;
      end else begin
        aw_done_s <= s_awd; w_done_s <= s_wd;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0; n_b <= n_b + 1;
      end
      if (s_ar_hs) begin
        m_axi_arready <= 1'b0; ar_cnt <= 0; m_axi_rvalid <= 1'b1;
        m_axi_rdata <= mem[m_axi_araddr[3:2]]; m_axi_rresp <= 2'b00;
      end else if (m_axi_arvalid && !m_axi_arready && !ar_never) begin
        if (ar_cnt + 1 >= ar_delay) m_axi_arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  task automatic issue_cmd(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge aclk); #1; n++;
    end
  endtask

  task automatic consume_rsp;
    rsp_ready = 1'b1;
    @(posedge aclk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      errors++; $display("FAIL reset_axi_ctrl: got %b want 00000",
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b0) begin
      errors++; $display("FAIL reset_rsp: got %b want 0000", {rsp_valid, rsp_timeout, rsp_resp}); end
    checks++; if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, rsp_rdata} !== 72'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {m_axi_awaddr, m_axi_araddr, m_axi_wdata, rsp_rdata}); end
  endtask

  task automatic test_write;
    int n, aw0, w0, b0;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    issue_cmd(1'b1, 4'h4, 32'hA5A5_1234, 4'hF);
    checks++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11 || m_axi_awaddr !== 4'h4 || m_axi_wdata !== 32'hA5A5_1234) begin
      errors++; $display("FAIL wr_req_drive: got v=%b addr=%h data=%h want v=11 addr=4 data=a5a51234",
        {m_axi_awvalid, m_axi_wvalid}, m_axi_awaddr, m_axi_wdata); end
    wait_rsp(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", n); end
    checks++; if (rsp_resp !== 2'b00 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL wr_rsp: got resp=%b to=%b rdata=%h want 00 0 0", rsp_resp, rsp_timeout, rsp_rdata); end
    checks++; if (n_aw - aw0 !== 1 || n_w - w0 !== 1 || n_b - b0 !== 1) begin
      errors++; $display("FAIL wr_handshakes: got aw=%0d w=%0d b=%0d want 1 1 1", n_aw - aw0, n_w - w0, n_b - b0); end
    consume_rsp();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr_done_idle: got rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_read;
    int n;
    issue_cmd(1'b0, 4'h4, 32'h0, 4'h0);
    checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 4'h4) begin
      errors++; $display("FAIL rd_req_drive: got arvalid=%b araddr=%h want 1 4", m_axi_arvalid, m_axi_araddr); end
    wait_rsp(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", n); end
    checks++; if (rsp_rdata !== 32'hA5A5_1234 || rsp_resp !== 2'b00) begin
      errors++; $display("FAIL rd_data1: got %h/%b want a5a51234/00", rsp_rdata, rsp_resp); end
    consume_rsp();
    issue_cmd(1'b1, 4'h4, 32'h0000_FF00, 4'h2);
    wait_rsp(n);
    consume_rsp();
    issue_cmd(1'b0, 4'h4, 32'h0, 4'h0);
    wait_rsp(n);
    checks++; if (rsp_rdata !== 32'hA5A5_FF34) begin
      errors++; $display("FAIL rd_strobe_merge: got %h want a5a5ff34", rsp_rdata); end
    consume_rsp();
  endtask

  task automatic test_aw_stall;
    int k, w_drop, aw_drop, addr_bad, data_bad, aw0, w0, b0, n;
    aw_delay = 5; w_delay = 1; m_axi_bresp = 2'b01;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    k = 0; w_drop = -1; aw_drop = -1; addr_bad = 0; data_bad = 0;
    issue_cmd(1'b1, 4'h8, 32'h1111_2222, 4'hF);
    while (!rsp_valid && k < 40) begin
      @(posedge aclk); #1; k++;
      if (!m_axi_wvalid && w_drop < 0) w_drop = k;
      if (!m_axi_awvalid && aw_drop < 0) aw_drop = k;
      if (m_axi_awvalid && m_axi_awaddr !== 4'h8) addr_bad++;
      if (m_axi_awvalid && m_axi_wdata !== 32'h1111_2222) data_bad++;
    end
    checks++; if (w_drop !== 2 || aw_drop !== 6) begin
      errors++; $display("FAIL stall_drop_order: got w=%0d aw=%0d want 2 6", w_drop, aw_drop); end
    checks++; if (addr_bad !== 0 || data_bad !== 0) begin
      errors++; $display("FAIL stall_hold: got addr_bad=%0d data_bad=%0d want 0 0", addr_bad, data_bad); end
    checks++; if (k !== 7 || rsp_resp !== 2'b01 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL stall_rsp: got cyc=%0d resp=%b to=%b want 7 01 0", k, rsp_resp, rsp_timeout); end
    checks++; if (n_aw - aw0 !== 1 || n_w - w0 !== 1 || n_b - b0 !== 1) begin
      errors++; $display("FAIL stall_handshakes: got aw=%0d w=%0d b=%0d want 1 1 1", n_aw - aw0, n_w - w0, n_b - b0); end
    consume_rsp();
    aw_delay = 1; m_axi_bresp = 2'b00;
    issue_cmd(1'b0, 4'h8, 32'h0, 4'h0);
    wait_rsp(n);
    checks++; if (rsp_rdata !== 32'h1111_2222) begin
      errors++; $display("FAIL stall_readback: got %h want 11112222", rsp_rdata); end
    consume_rsp();
  endtask

  task automatic test_rsp_stall;
    int n, bad;
    issue_cmd(1'b0, 4'h4, 32'h0, 4'h0);
    wait_rsp(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL hold_latency: got %0d want 3", n); end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_FF34 || rsp_resp !== 2'b00 ||
          cmd_ready !== 1'b0 || m_axi_awvalid !== 1'b0 || m_axi_arvalid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    cmd_valid = 1'b0;
    consume_rsp();
    checks++; if (cmd_ready !== 1'b1 || m_axi_awvalid !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: got cmd_ready=%b awvalid=%b rsp_valid=%b want 1 0 0",
        cmd_ready, m_axi_awvalid, rsp_valid); end
  endtask

  task automatic test_timeout;
    int k, hi;
    ar_never = 1'b1;
    issue_cmd(1'b0, 4'h0, 32'h0, 4'h0);
    checks++; if (m_axi_arvalid !== 1'b1) begin errors++; $display("FAIL to_arvalid_start: got %b want 1", m_axi_arvalid); end
    k = 0; hi = 0;
    while (!rsp_valid && k < 40) begin
      @(posedge aclk); #1; k++;
      if (m_axi_arvalid) hi++;
    end
    checks++; if (k !== 8 || hi !== 7 || m_axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL to_timing: got cyc=%0d high=%0d arvalid=%b want 8 7 0", k, hi, m_axi_arvalid); end
    checks++; if (rsp_timeout !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL to_rsp: got to=%b resp=%b rdata=%h want 1 10 0", rsp_timeout, rsp_resp, rsp_rdata); end
    consume_rsp();
    ar_never = 1'b0;
  endtask

  task automatic test_reset_mid;
    int k, pulses, n;
    b_block = 1'b1;
    issue_cmd(1'b1, 4'hC, 32'hDEAD_BEEF, 4'hF);
    k = 0;
    while (!m_axi_bready && k < 20) begin
      @(posedge aclk); #1; k++;
    end
    checks++; if (k !== 2) begin errors++; $display("FAIL rst_reach_wr_resp: got %0d want 2", k); end
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0; b_block = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got cmd_ready=%b axi=%b want 1 00000", cmd_ready,
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    checks++; if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== 40'h0 || {rsp_valid, rsp_timeout, rsp_resp} !== 4'b0) begin
      errors++; $display("FAIL rst_mid_data: got %h rsp=%b want 0 0000",
        {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, {rsp_valid, rsp_timeout, rsp_resp}); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk); #1;
      if (rsp_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_rsp: got %0d want 0", pulses); end
    issue_cmd(1'b0, 4'h4, 32'h0, 4'h0);
    wait_rsp(n);
    checks++; if (n !== 3 || rsp_rdata !== 32'hA5A5_FF34 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL rst_recover: got cyc=%0d rdata=%h to=%b want 3 a5a5ff34 0", n, rsp_rdata, rsp_timeout); end
    consume_rsp();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_aw_stall();
    test_rsp_stall();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
